// File: rtl/fir_filter_pkg.sv
// ---------------------------------------------------------------------------
// fir_filter_pkg
// Shared constants and types for the serial front end.
//   DESER_LENGTH_DEFAULT : default deserializer word width
//   deser_state_e        : deserializer FSM state encoding
//   odd_ones()           : parity helper (1 when the vector has an odd
//                          number of ones)
// Build option: DESERIALIZER_PARITY_EN adds the PARITY state.
// ---------------------------------------------------------------------------
package fir_filter_pkg;

  localparam int DESER_LENGTH_DEFAULT = 24;

`ifdef DESERIALIZER_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } deser_state_e;
`else
  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } deser_state_e;
`endif

  // XOR reduction; callers zero-extend narrower words to 64 bits.
  function automatic logic odd_ones(input logic [63:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/deserializer.sv
// ---------------------------------------------------------------------------
// deserializer
// Collects LSB-first serial bits into a LENGTH-bit word and presents it on a
// valid/ready output register.
//
// Ports
//   i_clk         : clock, rising edge
//   i_rst         : synchronous active-high reset, overrides everything
//   i_en          : serial-side enable (shift register, counter, FSM hold
//                   when low)
//   i_din         : serial data, LSB first
//   i_din_valid   : qualifies i_din; a bit is consumed on i_en && i_din_valid
//   ov_dout       : assembled word
//   o_dout_valid  : ov_dout holds an unaccepted word
//   i_dout_ready  : downstream accepts when o_dout_valid && i_dout_ready
//   o_busy        : FSM not in IDLE
//   o_overrun     : one-cycle pulse when a completed word is dropped
//   o_parity_err  : (DESERIALIZER_PARITY_EN only) even-parity error,
//                   registered with ov_dout
//
// Build option: DESERIALIZER_PARITY_EN -- each frame carries one trailing
// even-parity bit, consumed in state PARITY; completion happens there.
// ---------------------------------------------------------------------------
module deserializer
  import fir_filter_pkg::*;
#(
  parameter int LENGTH = DESER_LENGTH_DEFAULT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_din,
  input  logic              i_din_valid,
  output logic [LENGTH-1:0] ov_dout,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic              o_busy,
  output logic              o_overrun
`ifdef DESERIALIZER_PARITY_EN
  ,
  output logic              o_parity_err
`endif
);

  localparam int            CW       = $clog2(LENGTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(LENGTH - 1);

  deser_state_e      r_state;
  deser_state_e      w_state_nxt;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [LENGTH-1:0] r_shift;
  logic [LENGTH-1:0] w_shift_nxt;
  logic [LENGTH-1:0] w_shifted;
  logic [LENGTH-1:0] w_word;
  logic              w_consume;
  logic              w_complete;
  logic              w_load;
  logic              w_drop;
  logic [LENGTH-1:0] r_dout;
  logic              r_dout_valid;
  logic              r_overrun;
`ifdef DESERIALIZER_PARITY_EN
  logic              w_perr;
  logic              r_parity_err;
`endif

  assign w_consume = i_en & i_din_valid;
  // New bits enter at the MSB so the first bit of a frame ends in bit 0.
  assign w_shifted = {i_din, r_shift[LENGTH-1:1]};

  // Next-state, counter and shift-register update.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_complete  = 1'b0;
    w_word      = w_shifted;
`ifdef DESERIALIZER_PARITY_EN
    w_perr      = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (w_consume) begin
          w_shift_nxt = w_shifted;
          w_cnt_nxt   = CW'(1);
          w_state_nxt = ST_SHIFT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (w_consume) begin
          w_shift_nxt = w_shifted;
          if (r_cnt == LAST_IDX) begin
            w_cnt_nxt   = {CW{1'b0}};
`ifdef DESERIALIZER_PARITY_EN
            w_state_nxt = ST_PARITY;
`else
            w_state_nxt = ST_IDLE;
            w_complete  = 1'b1;
`endif
          end else begin
            w_cnt_nxt = r_cnt + CW'(1);
          end
        end else begin
          w_state_nxt = ST_SHIFT;
        end
      end
`ifdef DESERIALIZER_PARITY_EN
      ST_PARITY: begin
        // Shift register already holds the full word; this bit is parity only.
        if (w_consume) begin
          w_complete  = 1'b1;
          w_word      = r_shift;
          w_perr      = odd_ones(64'(r_shift)) ^ i_din;
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_PARITY;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = {CW{1'b0}};
      end
    endcase
  end

  // A completed word loads only if the output slot is free this cycle.
  assign w_load = w_complete & (~r_dout_valid | i_dout_ready);
  assign w_drop = w_complete & r_dout_valid & ~i_dout_ready;

  // Serial-side state registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= {CW{1'b0}};
      r_shift <= {LENGTH{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_shift <= w_shift_nxt;
    end
  end

  // Output register and handshake; independent of i_en.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dout       <= {LENGTH{1'b0}};
      r_dout_valid <= 1'b0;
      r_overrun    <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_overrun <= w_drop;
      if (w_load) begin
        r_dout       <= w_word;
        r_dout_valid <= 1'b1;
`ifdef DESERIALIZER_PARITY_EN
        r_parity_err <= w_perr;
`endif
      end else if (r_dout_valid && i_dout_ready) begin
        r_dout_valid <= 1'b0;
      end
    end
  end

  assign ov_dout      = r_dout;
  assign o_dout_valid = r_dout_valid;
  assign o_overrun    = r_overrun;
  assign o_busy       = (r_state != ST_IDLE);
`ifdef DESERIALIZER_PARITY_EN
  assign o_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_deserializer.sv
// ---------------------------------------------------------------------------
// tb_deserializer
// Directed bench for deserializer (LENGTH=24) with a frame-level reference
// model and per-cycle output comparison.
// Build option: DESERIALIZER_PARITY_EN enables the parity frames and port.
// ---------------------------------------------------------------------------
module tb_deserializer;

  localparam int L = 24;
`ifdef DESERIALIZER_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FRAME = L + PAR;

  logic         i_clk;
  logic         i_rst;
  logic         i_en;
  logic         i_din;
  logic         i_din_valid;
  logic [L-1:0] ov_dout;
  logic         o_dout_valid;
  logic         i_dout_ready;
  logic         o_busy;
  logic         o_overrun;
`ifdef DESERIALIZER_PARITY_EN
  logic         o_parity_err;
`endif

  int n_vec = 0;
  int n_err = 0;

  deserializer #(.LENGTH(L)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_din        (i_din),
    .i_din_valid  (i_din_valid),
    .ov_dout      (ov_dout),
    .o_dout_valid (o_dout_valid),
    .i_dout_ready (i_dout_ready),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun)
`ifdef DESERIALIZER_PARITY_EN
    ,
    .o_parity_err (o_parity_err)
`endif
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: counts consumed bits of a frame, places data bit k at
  // word position k, and applies the hold/drop rules to a one-entry slot.
  int           m_bits = 0;
  logic [L-1:0] m_acc  = '0;
  logic [L-1:0] m_dout = '0;
  logic         m_valid = 1'b0;
  logic         m_ovr   = 1'b0;
  logic         m_perr  = 1'b0;
  logic         m_pbit  = 1'b0;
  bit           chk_en  = 1'b0;

  always @(posedge i_clk) begin : model
    logic cpl;
    cpl = 1'b0;
    if (i_rst) begin
      m_bits  = 0;
      m_dout  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_perr  = 1'b0;
      m_pbit  = 1'b0;
      chk_en  = 1'b1;
    end else begin
      m_ovr = 1'b0;
      if (i_en && i_din_valid) begin
        if (m_bits < L) m_acc[m_bits] = i_din;
        else m_pbit = i_din;
        m_bits++;
        if (m_bits == FRAME) begin
          cpl    = 1'b1;
          m_bits = 0;
        end
      end
      if (cpl) begin
        if (!m_valid || i_dout_ready) begin
          m_dout  = m_acc;
          m_valid = 1'b1;
          m_perr  = (^m_acc) ^ m_pbit;
        end else begin
          m_ovr = 1'b1;
        end
      end else if (m_valid && i_dout_ready) begin
        m_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison on the falling edge.
  always @(negedge i_clk) begin
    if (chk_en) begin
      chk("dout",    64'(ov_dout),      64'(m_dout));
      chk("valid",   64'(o_dout_valid), 64'(m_valid));
      chk("busy",    64'(o_busy),       64'(m_bits != 0));
      chk("overrun", 64'(o_overrun),    64'(m_ovr));
`ifdef DESERIALIZER_PARITY_EN
      if (m_valid) chk("parity_err", 64'(o_parity_err), 64'(m_perr));
`endif
    end
  end

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  // Sends one frame (plus parity bit when enabled). A stall of stall_len
  // cycles is inserted before bit stall_at: either i_din_valid low, or i_en
  // low with valid data and i_dout_ready raised. Reports the step count at
  // which o_dout_valid was first seen high, and the number of overrun pulses.
  task automatic send_frame(input logic [L-1:0] w, input logic pbit,
                            input int stall_at, input int stall_len,
                            input bit stall_en_low,
                            output int first_valid, output int ovr);
    int cycles;
    cycles      = 0;
    first_valid = -1;
    ovr         = 0;
    for (int b = 0; b < FRAME; b++) begin
      if (b == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          if (stall_en_low) begin
            i_en         = 1'b0;
            i_din_valid  = 1'b1;
            i_din        = 1'($urandom_range(0, 1));
            i_dout_ready = 1'b1;
          end else begin
            i_en        = 1'b1;
            i_din_valid = 1'b0;
            i_din       = ~i_din;
          end
          step();
          cycles++;
          ovr += int'(o_overrun);
          if (first_valid < 0 && o_dout_valid) first_valid = cycles;
        end
      end
      i_en        = 1'b1;
      i_din_valid = 1'b1;
      i_din       = (b < L) ? w[b] : pbit;
      step();
      cycles++;
      ovr += int'(o_overrun);
      if (first_valid < 0 && o_dout_valid) first_valid = cycles;
    end
    i_din_valid = 1'b0;
  endtask

  initial begin : stim
    int fv;
    int ov;
    int ov_total;
    logic [L-1:0] w;
    i_rst        = 1'b1;
    i_en         = 1'b1;
    i_din        = 1'b0;
    i_din_valid  = 1'b1;
    i_dout_ready = 1'b0;
    step();
    step();
    chk("rst_dout",    64'(ov_dout),      64'h0);
    chk("rst_valid",   64'(o_dout_valid), 64'h0);
    chk("rst_busy",    64'(o_busy),       64'h0);
    chk("rst_overrun", 64'(o_overrun),    64'h0);
    i_rst       = 1'b0;
    i_din_valid = 1'b0;
    step();

    // Plain frame, downstream always ready.
    i_dout_ready = 1'b1;
    w = 24'hA5C3F1;
    send_frame(w, ^w, -1, 0, 1'b0, fv, ov);
    chk("f1_dout",    64'(ov_dout),      64'hA5C3F1);
    chk("f1_valid",   64'(o_dout_valid), 64'h1);
    chk("f1_latency", 64'(fv),           64'(FRAME));
    step();
    chk("f1_accept",  64'(o_dout_valid), 64'h0);

    // Same frame with three idle data cycles after bit 5.
    send_frame(w, ^w, 5, 3, 1'b0, fv, ov);
    chk("f2_dout",    64'(ov_dout),      64'hA5C3F1);
    chk("f2_latency", 64'(fv),           64'(FRAME + 3));
    chk("f2_overrun", 64'(ov),           64'h0);
    step();

    // Back-to-back frames with downstream stalled: second word dropped.
    i_dout_ready = 1'b0;
    ov_total = 0;
    w = 24'h000001;
    send_frame(w, ^w, -1, 0, 1'b0, fv, ov);
    ov_total += ov;
    w = 24'h800000;
    send_frame(w, ^w, -1, 0, 1'b0, fv, ov);
    ov_total += ov;
    chk("b2b_overruns", 64'(ov_total),     64'h1);
    chk("b2b_dout",     64'(ov_dout),      64'h000001);
    chk("b2b_valid",    64'(o_dout_valid), 64'h1);
    i_dout_ready = 1'b1;
    step();
    chk("b2b_drain_valid", 64'(o_dout_valid), 64'h0);
    chk("b2b_drain_dout",  64'(ov_dout),      64'h000001);

    // Reset after 10 bits, then a full frame.
    for (int b = 0; b < 10; b++) begin
      i_en        = 1'b1;
      i_din_valid = 1'b1;
      i_din       = 1'b1;
      step();
    end
    chk("mid_busy", 64'(o_busy), 64'h1);
    i_rst = 1'b1;
    step();
    i_rst       = 1'b0;
    i_din_valid = 1'b0;
    chk("mid_rst_busy",  64'(o_busy),       64'h0);
    chk("mid_rst_valid", 64'(o_dout_valid), 64'h0);
    chk("mid_rst_dout",  64'(ov_dout),      64'h0);
    w = 24'h123456;
    send_frame(w, ^w, -1, 0, 1'b0, fv, ov);
    chk("post_rst_dout",    64'(ov_dout), 64'h123456);
    chk("post_rst_latency", 64'(fv),      64'(FRAME));
    step();

    // Enable low for 4 cycles mid-frame; held word accepted during the stall.
    i_dout_ready = 1'b0;
    w = 24'h0F0F0F;
    send_frame(w, ^w, -1, 0, 1'b0, fv, ov);
    chk("en_held_valid", 64'(o_dout_valid), 64'h1);
    w = 24'h5A5A5A;
    send_frame(w, ^w, 12, 4, 1'b1, fv, ov);
    chk("en_dout",    64'(ov_dout),      64'h5A5A5A);
    chk("en_valid",   64'(o_dout_valid), 64'h1);
    chk("en_overrun", 64'(ov),           64'h0);
    step();

`ifdef DESERIALIZER_PARITY_EN
    // Parity: two ones in data, so parity bit 1 is an error and 0 is not.
    i_dout_ready = 1'b1;
    w = 24'h000003;
    send_frame(w, 1'b1, -1, 0, 1'b0, fv, ov);
    chk("par1_dout", 64'(ov_dout),      64'h000003);
    chk("par1_err",  64'(o_parity_err), 64'h1);
    step();
    send_frame(w, 1'b0, -1, 0, 1'b0, fv, ov);
    chk("par0_err",  64'(o_parity_err), 64'h0);
    step();
`endif

    step();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/deserializer.md
DESERIALIZER -- requirements
Module: deserializer

Interface
REQ-001 The block SHALL have parameter LENGTH, default 24, giving the data word width in bits; legal range is 2..64.
REQ-002 The block SHALL have port i_clk, input, 1 bit: clock; all logic is rising-edge.
REQ-003 The block SHALL have port i_rst, input, 1 bit: reset, synchronous, active-high.
REQ-004 The block SHALL have port i_en, input, 1 bit: serial-side enable; when low, the shift register, bit counter and FSM hold.
REQ-005 The block SHALL have port i_din, input, 1 bit: serial data, LSB first.
REQ-006 The block SHALL have port i_din_valid, input, 1 bit: qualifies i_din; a bit is consumed only when i_en && i_din_valid.
REQ-007 The block SHALL have port ov_dout, output, LENGTH bits: assembled word.
REQ-008 The block SHALL have port o_dout_valid, output, 1 bit: ov_dout holds an unaccepted word.
REQ-009 The block SHALL have port i_dout_ready, input, 1 bit: downstream accepts the word when o_dout_valid && i_dout_ready.
REQ-010 The block SHALL have port o_busy, output, 1 bit: high while the FSM is not IDLE.
REQ-011 The block SHALL have port o_overrun, output, 1 bit: one-cycle pulse when a completed word is dropped.

Function
REQ-012 The FSM SHALL have states IDLE, SHIFT and, with parity enabled, PARITY.
REQ-013 In IDLE, a consumed bit SHALL be stored and SHALL set the bit counter to 1, and the FSM SHALL enter SHIFT.
REQ-014 In SHIFT, each consumed bit SHALL be shifted in as {i_din, shift[LENGTH-1:1]}, so the first received bit lands in bit 0.
REQ-015 Cycles with i_din_valid low mid-frame SHALL stall the counter and shift register without aborting the frame.
REQ-016 Consumption of bit number LENGTH SHALL complete the word, return the FSM to IDLE (or enter PARITY), and clear the counter to 0.
REQ-017 On completion, if the output register is empty or is accepted in the same cycle, the word SHALL load into ov_dout and o_dout_valid SHALL be 1 on the following cycle (latency: 1 cycle after the last bit edge).
REQ-018 On completion while o_dout_valid=1 and i_dout_ready=0, the new word SHALL be discarded, ov_dout SHALL be unchanged, and o_overrun SHALL pulse for exactly 1 cycle.
REQ-019 Acceptance without a simultaneous load SHALL clear o_dout_valid on the next cycle; ov_dout SHALL retain its last value.
REQ-020 The output handshake SHALL operate regardless of i_en.
REQ-021 A bit consumed in the completion cycle SHALL NOT be lost; back-to-back frames with no idle cycle SHALL be supported.
REQ-022 The counter SHALL be $clog2(LENGTH+1) bits wide and SHALL never exceed LENGTH.

Reset
REQ-023 i_rst SHALL override i_en and all handshakes, and SHALL drive the FSM to IDLE with counter=0, shift register=0, ov_dout=0, o_dout_valid=0, o_busy=0, o_overrun=0 (and o_parity_err=0 when present) on the next edge.
REQ-024 A reset mid-frame SHALL discard the partial word, and no o_dout_valid SHALL result from it.

Configuration
REQ-025 When macro DESERIALIZER_PARITY_EN is defined, each frame SHALL carry one extra even-parity bit after the LENGTH data bits, consumed in state PARITY.
REQ-026 When DESERIALIZER_PARITY_EN is defined, port o_parity_err (1 bit) SHALL be registered alongside ov_dout and SHALL be 1 when the XOR of data plus parity bit is 1.
REQ-027 When DESERIALIZER_PARITY_EN is defined, completion SHALL occur at the parity bit, and the rules in REQ-017 to REQ-018 SHALL apply at that point.
REQ-028 When DESERIALIZER_PARITY_EN is undefined, there SHALL be no PARITY state and no o_parity_err port, and the frame SHALL be exactly LENGTH bits.

Structure
REQ-029 FSM state encodings and the default LENGTH constant SHALL reside in shared package fir_filter_pkg.
REQ-030 The block SHALL be a single module with no sub-module; the counter, shift register and output register are inline.

Verification
REQ-031 The bench SHALL check: LENGTH=24, i_dout_ready=1, bits of 0xA5C3F1 LSB-first on 24 consecutive cycles -> ov_dout=0xA5C3F1, o_dout_valid high 1 cycle after the 24th bit.
REQ-032 The bench SHALL check: the same frame with i_din_valid low on cycles 5..7 -> same word, valid delayed by 3 cycles, no overrun.
REQ-033 The bench SHALL check: two back-to-back frames 0x000001 and 0x800000 with i_dout_ready=0 -> first word held, o_overrun pulses once at the second completion, ov_dout=0x000001.
REQ-034 The bench SHALL check: i_rst asserted after 10 bits, then a full frame 0x123456 -> only 0x123456 is delivered.
REQ-035 The bench SHALL check: i_en=0 for 4 cycles mid-frame while i_din_valid=1 -> those bits are ignored, counter frozen, and acceptance still works.
REQ-036 The bench SHALL check, with DESERIALIZER_PARITY_EN: data 0x000003 with parity bit 1 -> o_parity_err=1; with parity bit 0 -> o_parity_err=0.
